// File: rtl/ram_clear_arbiter.sv
// Table RAM front end: a round-robin arbiter for two requesters, plus a
// sequential clear that rewrites every entry to INIT_WORD.
module ram_clear_arbiter #(
  parameter int          AW         = 14,
  parameter int          DW         = 14,
  parameter logic [DW-1:0] INIT_WORD = 14'h3000,
  parameter bit          AUTO_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam logic [AW-1:0] LAST = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          rv0_q, rv1_q;
  logic [DW-1:0] rd0_q, rd1_q;
  logic          g0, g1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    last_d   = last_q;
    done_d   = 1'b0;
    g0       = 1'b0;
    g1       = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (state_q)
      IDLE: begin
        if (pend_q | clr_start) begin
          state_d = CLEAR;
          pend_d  = 1'b0;
        end else if (rstn) begin
          // On contention, the side that was not granted last wins
          g0 = r0_req & (~r1_req | last_q);
          g1 = r1_req & (~r0_req | ~last_q);
        end
      end
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt_q;
        mem_din  = INIT_WORD;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (1'b1)
      g0: begin
        mem_we   = r0_we;
        mem_addr = r0_addr;
        mem_din  = r0_wdata;
        last_d   = 1'b0;
      end
      g1: begin
        mem_we   = r1_we;
        mem_addr = r1_addr;
        mem_din  = r1_wdata;
        last_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= AUTO_CLEAR;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      done_q  <= done_d;
      rv0_q   <= g0 & ~r0_we;
      rv1_q   <= g1 & ~r1_we;
      if (g0 & ~r0_we) rd0_q <= mem_dout;
      if (g1 & ~r1_we) rd1_q <= mem_dout;
    end
  end

  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = done_q;
  assign r0_gnt    = g0;
  assign r1_gnt    = g1;
  assign r0_rvalid = rv0_q;
  assign r1_rvalid = rv1_q;
  assign r0_rdata  = rd0_q;
  assign r1_rdata  = rd1_q;

endmodule
